// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX branch flushes and data-memory wait freezes with timeout flush.
// Controls are combinational from state and inputs (zero latency); a memory wait freezes PC..EX_MEM and bubbles MEM_WB.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RSaddr_i,
  input  logic [4:0]       ID_RTaddr_i,
  input  logic             ID_RSuse_i,
  input  logic             ID_RTuse_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RDaddr_i,
  input  logic             EX_BranchTaken_i,
  input  logic             MEM_MemAccess_i,
  input  logic             MEM_Ready_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_write_o,
  output logic             ID_EX_flush_o,
  output logic             EX_MEM_write_o,
  output logic             EX_MEM_flush_o,
  output logic             MEM_WB_bubble_o,
  output logic             bus_error_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MEM_WAIT  = 2'b01,
    ERR_FLUSH = 2'b10
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic in_err;
  logic freeze;
  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic br_sel;
  logic lu_sel;

  assign in_err = (state == ERR_FLUSH);
  assign freeze = !in_err && MEM_MemAccess_i && !MEM_Ready_i;

  assign rs_hit = ID_RSuse_i && (EX_RDaddr_i == ID_RSaddr_i);
  assign rt_hit = ID_RTuse_i && (EX_RDaddr_i == ID_RTaddr_i);
  assign lu     = EX_MemRead_i && (EX_RDaddr_i != 5'd0) && (rs_hit || rt_hit);

  // Priority: error flush > memory freeze > branch flush > load-use bubble.
  assign br_sel = !in_err && !freeze && EX_BranchTaken_i;
  assign lu_sel = !in_err && !freeze && !EX_BranchTaken_i && lu;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 8'd0;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MEM_Ready_i || !MEM_MemAccess_i) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ERR_FLUSH;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR_FLUSH: state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  // Output logic; reset overrides everything so the pipeline holds NOPs while rst_i is high.
  always_comb begin
    PC_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    IF_ID_flush_o   = 1'b0;
    ID_EX_write_o   = 1'b1;
    ID_EX_flush_o   = 1'b0;
    EX_MEM_write_o  = 1'b1;
    EX_MEM_flush_o  = 1'b0;
    MEM_WB_bubble_o = 1'b0;
    bus_error_o     = 1'b0;
    if (rst_i) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (in_err) begin
      PC_write_o      = 1'b0;
      IF_ID_flush_o   = 1'b1;
      ID_EX_flush_o   = 1'b1;
      EX_MEM_flush_o  = 1'b1;
      MEM_WB_bubble_o = 1'b1;
      bus_error_o     = 1'b1;
    end else if (freeze) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_write_o  = 1'b0;
      MEM_WB_bubble_o = 1'b1;
    end else if (br_sel) begin
      IF_ID_flush_o = 1'b1;
      ID_EX_flush_o = 1'b1;
    end else if (lu_sel) begin
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_flush_o = 1'b1;
    end
  end

  // Saturating performance counters; error flushes are not branch flushes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if ((freeze || lu_sel) && (stall_cycles_o != '1)) begin
        stall_cycles_o <= stall_cycles_o + CNT_ONE;
      end
      if (br_sel && (flush_count_o != '1)) begin
        flush_count_o <= flush_count_o + CNT_ONE;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-scenario tasks, expected controls queued at stimulus time and popped at sampling.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs, rt, rd;
  logic       rsu, rtu, mr, br, acc, rdy;

  logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, bub, berr;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  st;

  logic       pc_w4, ifid_w4, ifid_f4, idex_w4, idex_f4, exmem_w4, exmem_f4, bub4, berr4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic [1:0] st4;

  logic [8:0] ctl;
  assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, bub, berr};

  hazard_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_RSaddr_i(rs), .ID_RTaddr_i(rt), .ID_RSuse_i(rsu), .ID_RTuse_i(rtu),
    .EX_MemRead_i(mr), .EX_RDaddr_i(rd), .EX_BranchTaken_i(br),
    .MEM_MemAccess_i(acc), .MEM_Ready_i(rdy),
    .PC_write_o(pc_w), .IF_ID_write_o(ifid_w), .IF_ID_flush_o(ifid_f),
    .ID_EX_write_o(idex_w), .ID_EX_flush_o(idex_f),
    .EX_MEM_write_o(exmem_w), .EX_MEM_flush_o(exmem_f),
    .MEM_WB_bubble_o(bub), .bus_error_o(berr),
    .stall_cycles_o(stall_cnt), .flush_count_o(flush_cnt), .state_o(st)
  );

  hazard_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .ID_RSaddr_i(rs), .ID_RTaddr_i(rt), .ID_RSuse_i(rsu), .ID_RTuse_i(rtu),
    .EX_MemRead_i(mr), .EX_RDaddr_i(rd), .EX_BranchTaken_i(br),
    .MEM_MemAccess_i(acc), .MEM_Ready_i(rdy),
    .PC_write_o(pc_w4), .IF_ID_write_o(ifid_w4), .IF_ID_flush_o(ifid_f4),
    .ID_EX_write_o(idex_w4), .ID_EX_flush_o(idex_f4),
    .EX_MEM_write_o(exmem_w4), .EX_MEM_flush_o(exmem_f4),
    .MEM_WB_bubble_o(bub4), .bus_error_o(berr4),
    .stall_cycles_o(stall_cnt4), .flush_count_o(flush_cnt4), .state_o(st4)
  );

  // ctl bit order: pc_w ifid_w ifid_f idex_w idex_f exmem_w exmem_f bubble bus_error
  localparam logic [8:0] C_DEF = 9'b110101000;
  localparam logic [8:0] C_LU  = 9'b000111000;
  localparam logic [8:0] C_BR  = 9'b111111000;
  localparam logic [8:0] C_FRZ = 9'b000000010;
  localparam logic [8:0] C_ERR = 9'b011111111;
  localparam logic [8:0] C_RST = 9'b000000010;
  localparam logic [8:0] M_ALL = 9'b111111111;
  localparam logic [8:0] M_ERR = 9'b101010111;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       acc;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [8:0] ctl;
    logic [8:0] mask;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  in_t  si[$];
  exp_t se[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t mk_in(input logic [4:0] rs_, input logic [4:0] rt_, input logic rsu_,
                                input logic rtu_, input logic mr_, input logic [4:0] rd_,
                                input logic br_, input logic acc_, input logic rdy_);
    in_t v;
    v.rs = rs_; v.rt = rt_; v.rsu = rsu_; v.rtu = rtu_; v.mr = mr_;
    v.rd = rd_; v.br = br_; v.acc = acc_; v.rdy = rdy_;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [8:0] c, input logic [8:0] m, input logic [1:0] s);
    exp_t v;
    v.ctl = c; v.mask = m; v.st = s;
    return v;
  endfunction

  task automatic apply(input in_t i, input exp_t e);
    rs = i.rs; rt = i.rt; rsu = i.rsu; rtu = i.rtu; mr = i.mr;
    rd = i.rd; br = i.br; acc = i.acc; rdy = i.rdy;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    in_t idle;
    idle = '0;
    rst = 1'b1;
    apply(idle, mk_exp(C_RST, M_ALL, 2'b00));
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    apply(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), mk_exp(C_RST, M_ALL, 2'b00));
    #2;
    e = sb.pop_front();
    n_cmp++;
    if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
      n_bad++;
      $display("FAIL reset_ctl ctl=%b st=%b expected ctl=%b st=%b", ctl, st, e.ctl, e.st);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_cnt stall=%0d flush=%0d stall4=%0d expected 0", stall_cnt, flush_cnt, stall_cnt4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    si.delete(); se.delete();
    si.push_back(mk_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_LU,  M_ALL, 2'b00));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    for (int k = 0; k < si.size(); k++) begin
      apply(si[k], se[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL load_use[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL load_use_cnt stall=%0d flush=%0d expected 1/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_no_stall();
    exp_t e;
    do_reset();
    si.delete(); se.delete();
    si.push_back(mk_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    si.push_back(mk_in(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    si.push_back(mk_in(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_LU,  M_ALL, 2'b00));
    for (int k = 0; k < si.size(); k++) begin
      apply(si[k], se[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL no_stall[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL no_stall_cnt stall=%0d flush=%0d expected 1/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch_lu();
    exp_t e;
    do_reset();
    si.delete(); se.delete();
    si.push_back(mk_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0)); se.push_back(mk_exp(C_BR,  M_ALL, 2'b00));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    for (int k = 0; k < si.size(); k++) begin
      apply(si[k], se[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL branch_lu[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL branch_lu_cnt stall=%0d flush=%0d expected 0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    do_reset();
    si.delete(); se.delete();
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0)); se.push_back(mk_exp(C_FRZ, M_ALL, 2'b00));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0)); se.push_back(mk_exp(C_FRZ, M_ALL, 2'b01));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0)); se.push_back(mk_exp(C_FRZ, M_ALL, 2'b01));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1)); se.push_back(mk_exp(C_BR,  M_ALL, 2'b01));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    for (int k = 0; k < si.size(); k++) begin
      apply(si[k], se[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL mem_wait[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL mem_wait_cnt stall=%0d flush=%0d expected 3/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    si.delete(); se.delete();
    for (int k = 0; k < 16; k++) begin
      si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0));
      se.push_back(mk_exp(C_FRZ, M_ALL, (k == 0) ? 2'b00 : 2'b01));
    end
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); se.push_back(mk_exp(C_ERR, M_ERR, 2'b10));
    si.push_back(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); se.push_back(mk_exp(C_DEF, M_ALL, 2'b00));
    for (int k = 0; k < si.size(); k++) begin
      apply(si[k], se[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL timeout[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 32'd16 || flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL timeout_cnt stall=%0d flush=%0d expected 16/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_midwait();
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), mk_exp(C_FRZ, M_ALL, (k == 0) ? 2'b00 : 2'b01));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL midwait[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (st !== 2'b01 || stall_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL midwait_pre st=%b stall=%0d expected 01/5", st, stall_cnt);
    end
    rst = 1'b1;
    apply(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), mk_exp(C_RST, M_ALL, 2'b00));
    #2;
    e = sb.pop_front();
    n_cmp++;
    if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL midwait_rst ctl=%b st=%b stall=%0d flush=%0d expected ctl=%b st=%b 0/0",
               ctl, st, stall_cnt, flush_cnt, e.ctl, e.st);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), mk_exp(C_DEF, M_ALL, 2'b00));
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
      n_bad++;
      $display("FAIL midwait_after ctl=%b st=%b expected ctl=%b st=%b", ctl, st, e.ctl, e.st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(mk_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0), mk_exp(C_LU, M_ALL, 2'b00));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ((ctl & e.mask) !== (e.ctl & e.mask) || st !== e.st) begin
        n_bad++;
        $display("FAIL sat[%0d] ctl=%b st=%b expected ctl=%b st=%b", k, ctl, st, e.ctl, e.st);
      end
      @(posedge clk); #1;
      if (k == 14) begin
        n_cmp++;
        if (stall_cnt4 !== 4'd15) begin
          n_bad++;
          $display("FAIL sat_reach stall4=%0d expected 15", stall_cnt4);
        end
      end
    end
    n_cmp++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 32'd20 || flush_cnt4 !== 4'd0) begin
      n_bad++;
      $display("FAIL sat_hold stall4=%0d stall=%0d flush4=%0d expected 15/20/0", stall_cnt4, stall_cnt, flush_cnt4);
    end
  endtask

  initial begin
    rst = 1'b1;
    rs = '0; rt = '0; rd = '0;
    rsu = 1'b0; rtu = 1'b0; mr = 1'b0; br = 1'b0; acc = 1'b0; rdy = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_midwait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
